// File: rtl/cursor_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cursor_controller                                          |
// | Description : Moves a drawing cursor from four direction buttons, with   |
// |               press-and-hold auto-repeat, and cycles the brush color on  |
// |               each btn_color press.                                      |
// |               Optional feature macro: CURSOR_WRAP_EN makes the cursor    |
// |               wrap at the canvas edges; when undefined it clamps.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cursor_controller #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 2500000,
   parameter int COLOR_WIDTH  = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        btn_up,
   input  logic                        btn_down,
   input  logic                        btn_left,
   input  logic                        btn_right,
   input  logic                        btn_color,
   output logic [$clog2(WIDTH)-1:0]    cursor_x,
   output logic [$clog2(HEIGHT)-1:0]   cursor_y,
   output logic [COLOR_WIDTH-1:0]      current_color,
   output logic                        moved
);

   // Coordinate widths; WIDTH and HEIGHT must be at least 2.
   localparam int c_XW      = $clog2(WIDTH);
   localparam int c_YW      = $clog2(HEIGHT);
   localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int c_CW      = $clog2(c_CNT_MAX + 1);

   localparam logic [c_CW-1:0]        c_DELAY_LOAD = c_CW'(REPEAT_DELAY - 1);
   localparam logic [c_CW-1:0]        c_RATE_LOAD  = c_CW'(REPEAT_RATE - 1);
   localparam logic [c_XW-1:0]        c_X_HOME     = c_XW'(WIDTH / 2);
   localparam logic [c_YW-1:0]        c_Y_HOME     = c_YW'(HEIGHT / 2);
   localparam logic [c_XW-1:0]        c_X_LAST     = c_XW'(WIDTH - 1);
   localparam logic [c_YW-1:0]        c_Y_LAST     = c_YW'(HEIGHT - 1);
   localparam logic [COLOR_WIDTH-1:0] c_COLOR_NONE = '0;
   localparam logic [COLOR_WIDTH-1:0] c_COLOR_BLUE = COLOR_WIDTH'(1);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_DELAY  = 2'd1;
   localparam logic [1:0] c_ST_REPEAT = 2'd2;

   logic [1:0]             r_state;
   logic [c_CW-1:0]        r_cnt;
   logic [3:0]             r_vec;
   logic [c_XW-1:0]        r_x;
   logic [c_YW-1:0]        r_y;
   logic                   r_moved;
   logic [COLOR_WIDTH-1:0] r_color;
   logic                   r_color_prev;

   logic [1:0]             w_dx;
   logic [1:0]             w_dy;
   logic [3:0]             w_vec;
   logic [c_XW:0]          w_x_sum;
   logic [c_YW:0]          w_y_sum;
   logic [c_XW-1:0]        w_x_next;
   logic [c_YW-1:0]        w_y_next;
   logic [1:0]             w_state_next;
   logic [c_CW-1:0]        w_cnt_next;
   logic [3:0]             w_vec_next;
   logic                   w_step;
   logic                   w_color_rise;
   logic [COLOR_WIDTH-1:0] w_color_inc;
   logic [COLOR_WIDTH-1:0] w_color_next;

   // Two-bit two's-complement direction per axis: +1, 0 or -1.
   assign w_dx  = {1'b0, btn_right} - {1'b0, btn_left};
   assign w_dy  = {1'b0, btn_down}  - {1'b0, btn_up};
   assign w_vec = {w_dx, w_dy};

   // Candidate positions, one bit wider so an underflow shows up in the MSB.
   assign w_x_sum = {1'b0, r_x} + {{(c_XW-1){w_dx[1]}}, w_dx};
   assign w_y_sum = {1'b0, r_y} + {{(c_YW-1){w_dy[1]}}, w_dy};

   // Resolve the next column, handling both canvas edges.
   always_comb begin
      w_x_next = w_x_sum[c_XW-1:0];
      if (w_dx[1] && w_x_sum[c_XW]) begin
`ifdef CURSOR_WRAP_EN
         w_x_next = c_X_LAST;
`else
         w_x_next = '0;
`endif
      end else if (!w_dx[1] && (w_x_sum > {1'b0, c_X_LAST})) begin
`ifdef CURSOR_WRAP_EN
         w_x_next = '0;
`else
         w_x_next = c_X_LAST;
`endif
      end
   end

   // Resolve the next row, handling both canvas edges.
   always_comb begin
      w_y_next = w_y_sum[c_YW-1:0];
      if (w_dy[1] && w_y_sum[c_YW]) begin
`ifdef CURSOR_WRAP_EN
         w_y_next = c_Y_LAST;
`else
         w_y_next = '0;
`endif
      end else if (!w_dy[1] && (w_y_sum > {1'b0, c_Y_LAST})) begin
`ifdef CURSOR_WRAP_EN
         w_y_next = '0;
`else
         w_y_next = c_Y_LAST;
`endif
      end
   end

   // Auto-repeat sequencing: decide when a step happens and what comes next.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_vec_next   = r_vec;
      w_step       = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (w_vec != '0) begin
               w_step       = 1'b1;
               w_cnt_next   = c_DELAY_LOAD;
               w_vec_next   = w_vec;
               w_state_next = c_ST_DELAY;
            end
         end
         c_ST_DELAY, c_ST_REPEAT: begin
            if (w_vec == '0) begin
               w_state_next = c_ST_IDLE;
               w_cnt_next   = '0;
               w_vec_next   = '0;
            end else if (w_vec != r_vec) begin
               // A new combination restarts the hold as if freshly pressed.
               w_step       = 1'b1;
               w_cnt_next   = c_DELAY_LOAD;
               w_vec_next   = w_vec;
               w_state_next = c_ST_DELAY;
            end else if (r_cnt == '0) begin
               w_step       = 1'b1;
               w_cnt_next   = c_RATE_LOAD;
               w_state_next = c_ST_REPEAT;
            end else begin
               w_cnt_next   = r_cnt - c_CW'(1);
            end
         end
         default: begin
            w_state_next = c_ST_IDLE;
            w_cnt_next   = '0;
            w_vec_next   = '0;
         end
      endcase
   end

   // Next brush color: increment with wrap, never landing on the "no color" code.
   assign w_color_rise = btn_color & ~r_color_prev;
   assign w_color_inc  = r_color + COLOR_WIDTH'(1);
   assign w_color_next = (w_color_inc == c_COLOR_NONE) ? (w_color_inc + COLOR_WIDTH'(1))
                                                        : w_color_inc;

   // Repeat state, down-counter and latched direction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= '0;
         r_vec   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_vec   <= w_vec_next;
      end
   end

   // Cursor position and the moved pulse; a fully clamped step is not a move.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x     <= c_X_HOME;
         r_y     <= c_Y_HOME;
         r_moved <= 1'b0;
      end else begin
         r_moved <= w_step && ((w_x_next != r_x) || (w_y_next != r_y));
         if (w_step) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
         end
      end
   end

   // Brush color advances once per btn_color rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_color      <= c_COLOR_BLUE;
         r_color_prev <= 1'b0;
      end else begin
         r_color_prev <= btn_color;
         if (w_color_rise) begin
            r_color <= w_color_next;
         end
      end
   end

   assign cursor_x      = r_x;
   assign cursor_y      = r_y;
   assign current_color = r_color;
   assign moved         = r_moved;

endmodule
`default_nettype wire

// File: tb/tb_cursor_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cursor_controller                                       |
// | Description : Self-checking bench for cursor_controller on a 32x32       |
// |               canvas with short repeat timings. Build with               |
// |               CURSOR_WRAP_EN defined to check the wrapping variant.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cursor_controller;

   localparam int c_W       = 32;
   localparam int c_H       = 32;
   localparam int c_DLY     = 4;
   localparam int c_RATE    = 2;
   localparam int c_CWID    = 3;
   localparam int c_NCOLORS = (1 << c_CWID) - 1;   // codes 1..7, code 0 is "none"
   localparam int c_BLUE    = 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       btn_color = 1'b0;
   logic [4:0] cursor_x;
   logic [4:0] cursor_y;
   logic [2:0] current_color;
   logic       moved;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: position, color, and how long the current
   // direction has been held (-1 = nothing held).
   int m_x, m_y, m_color, m_hold, m_dx, m_dy;
   bit m_moved, m_cprev;

   always #5 clk = ~clk;

   cursor_controller #(
      .WIDTH        (c_W),
      .HEIGHT       (c_H),
      .REPEAT_DELAY (c_DLY),
      .REPEAT_RATE  (c_RATE),
      .COLOR_WIDTH  (c_CWID)
   ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_color     (btn_color),
      .cursor_x      (cursor_x),
      .cursor_y      (cursor_y),
      .current_color (current_color),
      .moved         (moved)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_x = c_W / 2;  m_y = c_H / 2;
      m_color = c_BLUE;
      m_moved = 1'b0; m_cprev = 1'b0;
      m_hold = -1; m_dx = 0; m_dy = 0;
   endtask

   // One clock edge of the reference: a step happens on the press edge, after
   // c_DLY held cycles, and then every c_RATE cycles.
   task automatic model_edge();
      int  dx, dy, nx, ny;
      bit  step;
      dx = int'(btn_right) - int'(btn_left);
      dy = int'(btn_down) - int'(btn_up);
      step = 1'b0;
      if (dx == 0 && dy == 0) begin
         m_hold = -1;
      end else if (m_hold < 0 || dx != m_dx || dy != m_dy) begin
         m_hold = 0; m_dx = dx; m_dy = dy; step = 1'b1;
      end else begin
         m_hold++;
         step = (m_hold == c_DLY) || (m_hold > c_DLY && ((m_hold - c_DLY) % c_RATE) == 0);
      end
      m_moved = 1'b0;
      if (step) begin
         nx = m_x + dx;
         ny = m_y + dy;
`ifdef CURSOR_WRAP_EN
         if (nx < 0) nx = c_W - 1; else if (nx >= c_W) nx = 0;
         if (ny < 0) ny = c_H - 1; else if (ny >= c_H) ny = 0;
`else
         if (nx < 0) nx = 0; else if (nx >= c_W) nx = c_W - 1;
         if (ny < 0) ny = 0; else if (ny >= c_H) ny = c_H - 1;
`endif
         m_moved = (nx != m_x) || (ny != m_y);
         m_x = nx; m_y = ny;
      end
      if (btn_color && !m_cprev) m_color = (m_color == c_NCOLORS) ? 1 : m_color + 1;
      m_cprev = btn_color;
   endtask

   task automatic check_all(input string tag);
      chk($sformatf("%s_x", tag),     32'(cursor_x),      m_x);
      chk($sformatf("%s_y", tag),     32'(cursor_y),      m_y);
      chk($sformatf("%s_color", tag), 32'(current_color), m_color);
      chk($sformatf("%s_moved", tag), 32'(moved),         32'(m_moved));
   endtask

   task automatic set_btns(input bit u, input bit d, input bit l, input bit r, input bit c);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_color = c;
   endtask

   // Called at a falling edge with inputs already applied; returns at the next falling edge.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   // Short reset between edges with buttons released; the outputs must jump home at once.
   task automatic apply_reset(input string tag);
      set_btns(0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #2;
      model_reset();
      check_all(tag);
      #2;
      reset_n = 1'b1;
      cycle({tag, "_post"});
   endtask

   task automatic tap(input bit u, input bit d, input bit l, input bit r, input string tag);
      set_btns(u, d, l, r, 0);
      cycle(tag);
      set_btns(0, 0, 0, 0, 0);
      cycle({tag, "_rel"});
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check_all("reset");
      reset_n = 1'b1;
      cycle("idle");

      // Hold right: 17 after the first edge, 18 four edges later, then every 2.
      set_btns(0, 0, 0, 1, 0);
      for (int i = 0; i < 11; i++) begin
         cycle("right_hold");
         if (i == 0) chk("right_first_x", 32'(cursor_x), 17);
         if (i == 4) chk("right_delay_x", 32'(cursor_x), 18);
      end
      chk("right_end_x", 32'(cursor_x), 21);
      set_btns(0, 0, 0, 0, 0);
      cycle("release");

      // Opposing vertical buttons cancel.
      set_btns(1, 1, 0, 0, 0);
      repeat (4) cycle("up_down");
      chk("up_down_y", 32'(cursor_y), 16);
      chk("up_down_moved", 32'(moved), 0);
      set_btns(0, 0, 0, 0, 0);
      cycle("release2");

      // Reset pulse while auto-repeating at (20,16).
      apply_reset("rst_a");
      set_btns(0, 0, 0, 1, 0);
      repeat (9) cycle("to_20");
      chk("pre_pulse_x", 32'(cursor_x), 20);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_pulse");
      chk("async_pulse_x", 32'(cursor_x), 16);
      #4;
      reset_n = 1'b1;
      @(negedge clk);
      cycle("after_pulse");
      chk("after_pulse_x", 32'(cursor_x), 17);
      set_btns(0, 0, 0, 0, 0);
      cycle("release3");

      // Walk to (0,5) with taps, then push left past the edge.
      apply_reset("rst_b");
      repeat (16) tap(0, 0, 1, 0, "tap_left");
      repeat (11) tap(1, 0, 0, 0, "tap_up");
      set_btns(0, 0, 1, 0, 0);
      cycle("edge_left");
`ifdef CURSOR_WRAP_EN
      chk("edge_left_x", 32'(cursor_x), 31);
      chk("edge_left_moved", 32'(moved), 1);
`else
      chk("edge_left_x", 32'(cursor_x), 0);
      chk("edge_left_moved", 32'(moved), 0);
`endif
      chk("edge_left_y", 32'(cursor_y), 5);
      set_btns(0, 0, 0, 0, 0);
      cycle("release4");

      // Corner (0,0) with left+up held.
      apply_reset("rst_c");
      repeat (16) tap(1, 0, 1, 0, "tap_diag");
      set_btns(1, 0, 1, 0, 0);
      repeat (6) cycle("corner");
`ifndef CURSOR_WRAP_EN
      chk("corner_x", 32'(cursor_x), 0);
      chk("corner_y", 32'(cursor_y), 0);
      chk("corner_moved", 32'(moved), 0);
`endif
      set_btns(0, 0, 0, 0, 0);
      cycle("release5");

      // Color: a 5-cycle hold and a second press give exactly two advances.
      apply_reset("rst_d");
      set_btns(0, 0, 0, 0, 1);
      repeat (5) cycle("color_hold");
      set_btns(0, 0, 0, 0, 0);
      cycle("color_rel");
      set_btns(0, 0, 0, 0, 1);
      cycle("color_press2");
      chk("color_two_adv", 32'(current_color), 3);
      set_btns(0, 0, 0, 0, 0);
      cycle("color_rel2");
      repeat (5) begin
         set_btns(0, 0, 0, 0, 1); cycle("color_cyc");
         set_btns(0, 0, 0, 0, 0); cycle("color_cyc_rel");
      end
      chk("color_wrap_blue", 32'(current_color), c_BLUE);
      repeat (c_NCOLORS) begin
         set_btns(0, 0, 0, 0, 1); cycle("color_full");
         set_btns(0, 0, 0, 0, 0); cycle("color_full_rel");
      end
      chk("color_full_blue", 32'(current_color), c_BLUE);

      // Randomized buttons with sticky holds so auto-repeat gets exercised.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            logic [4:0] b;
            b = 5'($urandom_range(0, 31));
            set_btns(b[0], b[1], b[2], b[3], b[4]);
         end
         if ($urandom_range(0, 199) == 0) apply_reset("rnd_rst");
         else cycle("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
